// File: rtl/rv_pipe_pkg.sv
// Shared encodings and the decoded control bundle for the RV32I pipeline core.
// The ID/EX stage and its register import everything from here.
package rv_pipe_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam int ALU_W = 3;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'd4;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'd5;
  localparam logic [ALU_W-1:0] ALU_SLL = 3'd6;
  localparam logic [ALU_W-1:0] ALU_SRL = 3'd7;

  typedef struct packed {
    logic             regWrite;
    logic             memWrite;
    logic             jump;
    logic             jalr;
    logic             branch;
    logic             aluSrc;
    logic             luau;
    logic [ALU_W-1:0] aluCtrl;
    logic [1:0]       resultSrc;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_reg.sv
// Priority-muxed ID/EX register: reset > flush > hold > bubble > capture.
// The payload is an opaque packed word; BUBBLE is what a squashed slot holds.
module id_ex_reg #(
  parameter int             W      = 8,
  parameter logic [W-1:0]   BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         stall,
  input  logic         bubbleReq,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         validQ
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= BUBBLE;
      validQ <= 1'b0;
    end else if (flush) begin
      q      <= BUBBLE;
      validQ <= 1'b0;
    end else if (stall) begin
      q      <= q;
      validQ <= validQ;
    end else if (bubbleReq) begin
      q      <= BUBBLE;
      validQ <= 1'b0;
    end else begin
      q      <= d;
      validQ <= 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage_p.sv
// Decode stage with ID/EX register: control/immediate decode, early branch/JAL
// target, load-use hazard detection and bubble/hold/flush of the EX side.
module id_ex_stage_p
  import rv_pipe_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          ALUCTRL_W    = 3,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_d,
  input  logic [XLEN-1:0]      pc_d,
  input  logic [XLEN-1:0]      pc_plus4_d,
  input  logic [XLEN-1:0]      rd1_d,
  input  logic [XLEN-1:0]      rd2_d,
  input  logic                 valid_d,
  input  logic                 predict_taken_d,
  input  logic                 stall_e,
  input  logic                 flush_e,
  output logic [4:0]           rs1_d,
  output logic [4:0]           rs2_d,
  output logic [XLEN-1:0]      pred_target_d,
  output logic                 redirect_d,
  output logic                 stall_d,
  output logic                 valid_e,
  output logic [31:0]          instr_e,
  output logic [XLEN-1:0]      pc_e,
  output logic [XLEN-1:0]      pc_plus4_e,
  output logic [XLEN-1:0]      rd1_e,
  output logic [XLEN-1:0]      rd2_e,
  output logic [XLEN-1:0]      imm_e,
  output logic [4:0]           rd_e,
  output logic [4:0]           rs1_e,
  output logic [4:0]           rs2_e,
  output logic                 reg_write_e,
  output logic                 mem_write_e,
  output logic                 jump_e,
  output logic                 jalr_e,
  output logic                 branch_e,
  output logic                 alu_src_e,
  output logic                 luau_e,
  output logic [ALUCTRL_W-1:0] alu_ctrl_e,
  output logic [1:0]           result_src_e,
  output logic                 predict_taken_e
);

  localparam int PAY_W = 32 + 5*XLEN + 15 + $bits(id_ex_ctrl_t) + 1;
  localparam logic [PAY_W-1:0] BUBBLE_WORD =
    {BUBBLE_INSTR, {(5*XLEN+15){1'b0}}, CTRL_BUBBLE, 1'b0};

  function automatic logic signed [31:0] immExtend(input logic [31:0] i,
                                                   input logic [2:0]  src);
    case (src)
      IMM_S:   immExtend = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   immExtend = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   immExtend = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_U:   immExtend = {i[31:12], 12'b0};
      default: immExtend = {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [2:0]       immSrcD;
  logic             usesRs1;
  logic             usesRs2;
  logic             isRType;
  logic [ALU_W-1:0] aluOpD;
  id_ex_ctrl_t      ctrlD;
  id_ex_ctrl_t      ctrlE;
  logic [XLEN-1:0]  immExtD;
  logic [PAY_W-1:0] payD;
  logic [PAY_W-1:0] payE;

  assign opcode  = instr_d[6:0];
  assign funct3  = instr_d[14:12];
  assign rs1_d   = instr_d[19:15];
  assign rs2_d   = instr_d[24:20];
  assign isRType = (opcode == OP_R);

  // SRA and SLTU share the SRL and SLT encodings in this 3-bit ALU map
  always_comb begin
    aluOpD = ALU_ADD;
    case (funct3)
      3'b000:  aluOpD = (isRType && instr_d[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  aluOpD = ALU_SLL;
      3'b010,
      3'b011:  aluOpD = ALU_SLT;
      3'b100:  aluOpD = ALU_XOR;
      3'b101:  aluOpD = ALU_SRL;
      3'b110:  aluOpD = ALU_OR;
      default: aluOpD = ALU_AND;
    endcase
  end

  always_comb begin
    ctrlD   = CTRL_BUBBLE;
    immSrcD = IMM_I;
    usesRs1 = 1'b1;
    usesRs2 = 1'b0;
    case (opcode)
      OP_R: begin
        ctrlD.regWrite = 1'b1;
        ctrlD.aluCtrl  = aluOpD;
        usesRs2        = 1'b1;
      end
      OP_I: begin
        ctrlD.regWrite = 1'b1;
        ctrlD.aluSrc   = 1'b1;
        ctrlD.aluCtrl  = aluOpD;
      end
      OP_LOAD: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.aluSrc    = 1'b1;
        ctrlD.resultSrc = RES_LOAD;
      end
      OP_S: begin
        ctrlD.memWrite = 1'b1;
        ctrlD.aluSrc   = 1'b1;
        immSrcD        = IMM_S;
        usesRs2        = 1'b1;
      end
      OP_B: begin
        ctrlD.branch  = 1'b1;
        ctrlD.aluCtrl = ALU_SUB;
        immSrcD       = IMM_B;
        usesRs2       = 1'b1;
      end
      OP_JAL: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.jump      = 1'b1;
        ctrlD.resultSrc = RES_PC4;
        immSrcD         = IMM_J;
        usesRs1         = 1'b0;
      end
      OP_JALR: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.jump      = 1'b1;
        ctrlD.jalr      = 1'b1;
        ctrlD.aluSrc    = 1'b1;
        ctrlD.resultSrc = RES_PC4;
      end
      OP_LUI, OP_AUIPC: begin
        ctrlD.regWrite = 1'b1;
        ctrlD.aluSrc   = 1'b1;
        ctrlD.luau     = 1'b1;
        immSrcD        = IMM_U;
        usesRs1        = 1'b0;
      end
      default: ;
    endcase
  end

  assign immExtD       = XLEN'(immExtend(instr_d, immSrcD));
  assign pred_target_d = pc_d + immExtD;

  // Load-use hazard against the instruction currently sitting in EX
  assign stall_d = valid_d & valid_e & (result_src_e == RES_LOAD) & (rd_e != 5'd0)
                 & ((usesRs1 & (rs1_d == rd_e)) | (usesRs2 & (rs2_d == rd_e)));

  assign redirect_d = valid_d & ~stall_d
                    & ((opcode == OP_JAL) | (ctrlD.branch & predict_taken_d));

  assign payD = {instr_d, pc_d, pc_plus4_d, rd1_d, rd2_d, immExtD,
                 instr_d[11:7], rs1_d, rs2_d, ctrlD, predict_taken_d};

  id_ex_reg #(
    .W      (PAY_W),
    .BUBBLE (BUBBLE_WORD)
  ) u_id_ex_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_e),
    .stall     (stall_e),
    .bubbleReq (stall_d | ~valid_d),
    .d         (payD),
    .q         (payE),
    .validQ    (valid_e)
  );

  assign {instr_e, pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e,
          rd_e, rs1_e, rs2_e, ctrlE, predict_taken_e} = payE;

  assign reg_write_e  = ctrlE.regWrite;
  assign mem_write_e  = ctrlE.memWrite;
  assign jump_e       = ctrlE.jump;
  assign jalr_e       = ctrlE.jalr;
  assign branch_e     = ctrlE.branch;
  assign alu_src_e    = ctrlE.aluSrc;
  assign luau_e       = ctrlE.luau;
  assign alu_ctrl_e   = ALUCTRL_W'(ctrlE.aluCtrl);
  assign result_src_e = ctrlE.resultSrc;

endmodule

// File: tb/tb_id_ex_stage_p.sv
// Directed-vector bench for id_ex_stage_p: reset, capture, load-use bubbles,
// hold/flush priority, branch target wrap and redirect qualification.
module tb_id_ex_stage_p;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d, pc_plus4_d, rd1_d, rd2_d;
  logic            valid_d, predict_taken_d, stall_e, flush_e;
  logic [4:0]      rs1_d, rs2_d;
  logic [XLEN-1:0] pred_target_d;
  logic            redirect_d, stall_d, valid_e;
  logic [31:0]     instr_e;
  logic [XLEN-1:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e;
  logic [4:0]      rd_e, rs1_e, rs2_e;
  logic            reg_write_e, mem_write_e, jump_e, jalr_e, branch_e, alu_src_e, luau_e;
  logic [2:0]      alu_ctrl_e;
  logic [1:0]      result_src_e;
  logic            predict_taken_e;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] I_ADD3   = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_LW5    = 32'h0080A283; // lw x5,8(x1)
  localparam logic [31:0] I_LW1    = 32'h0080A083; // lw x1,8(x1)
  localparam logic [31:0] I_LW0    = 32'h0080A003; // lw x0,8(x1)
  localparam logic [31:0] I_ADD6_5 = 32'h00128333; // add x6,x5,x1
  localparam logic [31:0] I_ADD6_R = 32'h00508333; // add x6,x1,x5
  localparam logic [31:0] I_ADD6_0 = 32'h00100333; // add x6,x0,x1
  localparam logic [31:0] I_LUI5   = 32'h000282B7; // lui x5,0x28 (rs1 field = 5)
  localparam logic [31:0] I_BEQ16  = 32'h00208863; // beq x1,x2,+16
  localparam logic [31:0] I_JAL32  = 32'h020000EF; // jal x1,+32
  localparam logic [31:0] I_JALR   = 32'h000100E7; // jalr x1,0(x2)
  localparam logic [31:0] NOP      = 32'h00000013;

  id_ex_stage_p #(.XLEN(XLEN), .ALUCTRL_W(3), .BUBBLE_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .valid_d(valid_d), .predict_taken_d(predict_taken_d),
    .stall_e(stall_e), .flush_e(flush_e), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .pred_target_d(pred_target_d), .redirect_d(redirect_d), .stall_d(stall_d),
    .valid_e(valid_e), .instr_e(instr_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .rd_e(rd_e), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .jump_e(jump_e), .jalr_e(jalr_e), .branch_e(branch_e), .alu_src_e(alu_src_e),
    .luau_e(luau_e), .alu_ctrl_e(alu_ctrl_e), .result_src_e(result_src_e),
    .predict_taken_e(predict_taken_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic vld, input logic pt);
    instr_d         = ins;
    pc_d            = pc;
    pc_plus4_d      = pc + 32'd4;
    valid_d         = vld;
    predict_taken_d = pt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBubble(input string tag);
    check({tag, ".valid"}, {31'b0, valid_e}, 32'd0);
    check({tag, ".instr"}, instr_e, NOP);
    check({tag, ".ctrl"}, {24'b0, reg_write_e, mem_write_e, jump_e, branch_e,
                           result_src_e, alu_ctrl_e != 3'd0, rd_e != 5'd0}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    rd1_d = 32'h0000AAAA; rd2_d = 32'h00005555;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    #3;
    checkBubble("rst0");
    check("rst0.pc", pc_e, 32'h0);

    // ADD capture
    rst = 1'b0;
    drive(I_ADD3, 32'h100, 1'b1, 1'b0);
    #1;
    check("add.rs1_d", {27'b0, rs1_d}, 32'd1);
    check("add.rs2_d", {27'b0, rs2_d}, 32'd2);
    step();
    check("add.valid", {31'b0, valid_e}, 32'd1);
    check("add.rd", {27'b0, rd_e}, 32'd3);
    check("add.rs1", {27'b0, rs1_e}, 32'd1);
    check("add.rs2", {27'b0, rs2_e}, 32'd2);
    check("add.rw", {31'b0, reg_write_e}, 32'd1);
    check("add.pc", pc_e, 32'h100);
    check("add.pc4", pc_plus4_e, 32'h104);
    check("add.rd1", rd1_e, 32'h0000AAAA);
    check("add.alusrc_ctl", {29'b0, alu_src_e, result_src_e}, 32'd0);

    // Asynchronous reset mid-cycle
    rst = 1'b1;
    #1;
    checkBubble("rstmid");
    check("rstmid.pc", pc_e, 32'h0);
    rst = 1'b0;

    // Load-use through rs1
    drive(I_LW5, 32'h200, 1'b1, 1'b0);
    step();
    check("lw.res", {30'b0, result_src_e}, 32'd1);
    check("lw.rd", {27'b0, rd_e}, 32'd5);
    check("lw.imm", imm_e, 32'd8);
    check("lw.alusrc", {31'b0, alu_src_e}, 32'd1);
    drive(I_ADD6_5, 32'h204, 1'b1, 1'b0);
    #1;
    check("lu.stall", {31'b0, stall_d}, 32'd1);
    step();
    checkBubble("lu.bub");
    check("lu.stall_clr", {31'b0, stall_d}, 32'd0);
    step();
    check("lu.cap.valid", {31'b0, valid_e}, 32'd1);
    check("lu.cap.instr", instr_e, I_ADD6_5);
    check("lu.cap.rd", {27'b0, rd_e}, 32'd6);

    // Hold for three cycles, then flush beats hold
    stall_e = 1'b1;
    drive(I_ADD3, 32'h300, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("hold.instr", instr_e, I_ADD6_5);
      check("hold.valid", {31'b0, valid_e}, 32'd1);
      check("hold.pc", pc_e, 32'h204);
    end
    flush_e = 1'b1;
    step();
    checkBubble("flush");
    flush_e = 1'b0;
    stall_e = 1'b0;

    // Load-use through rs2, with stall_e overlapping the hazard
    drive(I_LW5, 32'h400, 1'b1, 1'b0);
    step();
    drive(I_ADD6_R, 32'h404, 1'b1, 1'b0);
    stall_e = 1'b1;
    #1;
    check("lu2.stall", {31'b0, stall_d}, 32'd1);
    step();
    check("lu2.hold.instr", instr_e, I_LW5);
    check("lu2.hold.stall", {31'b0, stall_d}, 32'd1);
    stall_e = 1'b0;
    step();
    checkBubble("lu2.bub");
    step();
    check("lu2.cap.instr", instr_e, I_ADD6_R);

    // valid_d low loads a bubble
    drive(I_ADD3, 32'h500, 1'b0, 1'b0);
    step();
    checkBubble("inv");

    // Branch target wrap and redirect
    drive(I_BEQ16, 32'hFFFFFFF8, 1'b1, 1'b1);
    #1;
    check("beq.target", pred_target_d, 32'h00000008);
    check("beq.redir", {31'b0, redirect_d}, 32'd1);
    predict_taken_d = 1'b0;
    #1;
    check("beq.nt.redir", {31'b0, redirect_d}, 32'd0);
    predict_taken_d = 1'b1;
    step();
    check("beq.branch", {31'b0, branch_e}, 32'd1);
    check("beq.pt", {31'b0, predict_taken_e}, 32'd1);
    check("beq.imm", imm_e, 32'd16);
    check("beq.alu", {29'b0, alu_ctrl_e}, 32'd1);
    drive(I_JAL32, 32'h200, 1'b1, 1'b0);
    #1;
    check("jal.target", pred_target_d, 32'h220);
    check("jal.redir", {31'b0, redirect_d}, 32'd1);
    drive(I_JALR, 32'h200, 1'b1, 1'b1);
    #1;
    check("jalr.redir", {31'b0, redirect_d}, 32'd0);
    step();
    check("jalr.jump", {30'b0, jump_e, jalr_e}, 32'd3);
    check("jalr.res", {30'b0, result_src_e}, 32'd2);

    // Stalled branch must not redirect
    drive(I_LW1, 32'h600, 1'b1, 1'b0);
    step();
    drive(I_BEQ16, 32'h604, 1'b1, 1'b1);
    #1;
    check("sbr.stall", {31'b0, stall_d}, 32'd1);
    check("sbr.redir", {31'b0, redirect_d}, 32'd0);
    step();

    // No false stalls: x0 destination, LUI, invalid instruction
    drive(I_LW0, 32'h700, 1'b1, 1'b0);
    step();
    drive(I_ADD6_0, 32'h704, 1'b1, 1'b0);
    #1;
    check("x0.stall", {31'b0, stall_d}, 32'd0);
    drive(I_LW5, 32'h708, 1'b1, 1'b0);
    step();
    drive(I_LUI5, 32'h70C, 1'b1, 1'b0);
    #1;
    check("lui.rs1f", {27'b0, rs1_d}, 32'd5);
    check("lui.stall", {31'b0, stall_d}, 32'd0);
    drive(I_ADD6_5, 32'h70C, 1'b0, 1'b0);
    #1;
    check("invhaz.stall", {31'b0, stall_d}, 32'd0);
    drive(I_LUI5, 32'h70C, 1'b1, 1'b0);
    step();
    check("lui.luau", {31'b0, luau_e}, 32'd1);
    check("lui.imm", imm_e, 32'h00028000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
